// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serializes NREQ BN-byte frames, MSB byte first, into one uart_tx byte port.
// Optional `UART_TX_ARB_CHKSUM_EN appends an XOR-of-bytes checksum byte to every frame.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int BN        = 4,
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int GAP_BITS  = 1
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*BN*8-1:0]   req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   busy,
  output logic [7:0]             tx_data,
  output logic                   tx_data_valid,
  input  logic                   tx_data_ready
);

  localparam int     IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam longint GAP_CYC_L = (longint'(GAP_BITS) * longint'(CLK_FRE) * 64'sd1000000)
                                 / longint'(BAUD_RATE);
  localparam int     GAP_CYC   = int'(GAP_CYC_L);
  localparam int     GW        = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
`ifdef UART_TX_ARB_CHKSUM_EN
  localparam int     NB        = BN + 1;
`else
  localparam int     NB        = BN;
`endif
  localparam int             FW     = NB * 8;
  localparam logic [3:0]     LAST   = 4'(NB - 1);
  localparam logic [IW:0]    NREQ_W = (IW + 1)'(NREQ);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  state_t state, state_nxt;

  logic [NREQ-1:0][BN*8-1:0] frames;
  logic [IW-1:0]             rr_ptr, winner, pick;
  logic                      pick_vld;
  logic [FW-1:0]             frame, frame_ld;
  logic [3:0]                byte_cnt;
  logic [GW-1:0]             gap_cnt;
  logic                      xfer, last_xfer;
  logic [NREQ-1:0]           win_oh;

  assign frames = req_data;

  // First requester at or above rr_ptr, wrapping.
  always_comb begin
    logic [IW:0] cand;
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW + 1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!pick_vld && req[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = cand[IW-1:0];
      end
    end
  end

`ifdef UART_TX_ARB_CHKSUM_EN
  logic [7:0] chksum;
  always_comb begin
    chksum = '0;
    for (int b = 0; b < BN; b++) chksum = chksum ^ frames[pick][b*8 +: 8];
  end
  assign frame_ld = {frames[pick], chksum};
`else
  assign frame_ld = frames[pick];
`endif

  assign xfer      = tx_data_valid & tx_data_ready;
  assign last_xfer = xfer && (byte_cnt == LAST);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_vld)  state_nxt = SEND;
      SEND: if (last_xfer) state_nxt = (GAP_CYC == 0) ? DONE : GAP;
      GAP:  if (gap_cnt == GW'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame is a shift register: the outgoing byte is always its top byte.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      winner   <= '0;
      frame    <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          winner   <= pick;
          frame    <= frame_ld;
          byte_cnt <= '0;
        end
        SEND: if (xfer) begin
          frame    <= frame << 8;
          byte_cnt <= byte_cnt + 4'd1;
          if (last_xfer) gap_cnt <= GW'(GAP_CYC);
        end
        GAP:  gap_cnt <= gap_cnt - GW'(1);
        DONE: rr_ptr  <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
        default: ;
      endcase
    end
  end

  assign win_oh        = {{(NREQ-1){1'b0}}, 1'b1} << winner;
  assign busy          = (state != IDLE);
  assign gnt           = busy ? win_oh : '0;
  assign done          = (state == DONE) ? win_oh : '0;
  assign tx_data_valid = (state == SEND);
  assign tx_data       = frame[FW-1 -: 8];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte scoreboard, backpressure hold, round robin, gap, reset.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int BN   = 4;
`ifdef UART_TX_ARB_CHKSUM_EN
  localparam int NB = BN + 1;
`else
  localparam int NB = BN;
`endif

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = '0, req_b = '0;
  logic [127:0]  req_data = '0, req_data_b = '0;
  logic          tx_data_ready = 1'b0, rdy_b = 1'b0;
  logic [3:0]    gnt, done, gnt_b, done_b;
  logic          busy, busy_b, tx_data_valid, valid_b;
  logic [7:0]    tx_data, tx_data_b;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(.NREQ(NREQ), .BN(BN), .CLK_FRE(50), .BAUD_RATE(115200), .GAP_BITS(0)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .busy(busy), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready));

  uart_tx_arbiter #(.NREQ(NREQ), .BN(BN), .CLK_FRE(50), .BAUD_RATE(115200), .GAP_BITS(1)) dut_gap (
    .sys_clk(sys_clk), .rst_n(rst_n), .req(req_b), .req_data(req_data_b),
    .gnt(gnt_b), .done(done_b), .busy(busy_b), .tx_data(tx_data_b),
    .tx_data_valid(valid_b), .tx_data_ready(rdy_b));

  int          checks = 0, failures = 0;
  logic [31:0] fr [4];
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_b [$];
  logic [3:0]  who;
  bit [3:0]    pat = 4'b1001;
  bit          stall_pend = 1'b0;
  logic [7:0]  held = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_frame(input int i, input bit to_b);
    for (int b = BN - 1; b >= 0; b--)
      if (to_b) exp_b.push_back(fr[i][b*8 +: 8]);
      else      exp_q.push_back(fr[i][b*8 +: 8]);
`ifdef UART_TX_ARB_CHKSUM_EN
    begin
      logic [7:0] x;
      x = '0;
      for (int b = 0; b < BN; b++) x = x ^ fr[i][b*8 +: 8];
      if (to_b) exp_b.push_back(x);
      else      exp_q.push_back(x);
    end
`endif
  endtask

  task automatic run_done(input bit bp, input int budget, output logic [3:0] w);
    bit got;
    got = 1'b0;
    w = '0;
    for (int n = 0; n < budget && !got; n++) begin
      cyc();
      if (bp) tx_data_ready = pat[n % 4];
      if (|done) begin
        got = 1'b1;
        w   = done;
        req = req & ~done;
      end
    end
    tx_data_ready = 1'b1;
    chk("done_seen", 32'(got), 32'd1);
  endtask

  // Byte scoreboard and stall-hold monitor for the zero-gap instance.
  always @(negedge sys_clk) begin
    if (!rst_n) begin
      stall_pend <= 1'b0;
    end else begin
      if (stall_pend) begin
        chk("hold_valid", 32'(tx_data_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(held));
      end
      if (tx_data_valid && tx_data_ready)
        chk("byte", 32'(tx_data), (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hxx);
      if (|done) chk("done_gnt", 32'(done), 32'(gnt));
      stall_pend <= tx_data_valid && !tx_data_ready;
      held       <= tx_data;
    end
  end

  initial begin
    int cnt, last, gap;
    bit got;
    fr[0] = 32'h01020304;
    fr[1] = 32'h11223344;
    fr[2] = 32'hA1B2C3D4;
    fr[3] = 32'hF00FAA55;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = fr[i];
    req_data_b[31:0] = fr[3];

    // Reset state
    #12;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(tx_data_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single frame, ready tied high
    tx_data_ready = 1'b1;
    push_frame(2, 1'b0);
    req = 4'b0100;
    cyc();
    chk("t1_valid", 32'(tx_data_valid), 32'd1);
    chk("t1_gnt", 32'(gnt), 32'b0100);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_first", 32'(tx_data), 32'hA1);
    req = '0;
    repeat (NB) cyc();
    chk("t1_done", 32'(done), 32'b0100);
    chk("t1_gnt_done", 32'(gnt), 32'b0100);
    chk("t1_valid_off", 32'(tx_data_valid), 32'd0);
    cyc();
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_gnt_clr", 32'(gnt), 32'd0);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure 1,0,0,1,...
    push_frame(0, 1'b0);
    req = 4'b0001;
    run_done(1'b1, 60, who);
    chk("t2_who", 32'(who), 32'b0001);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    cyc();

    // Reset after two bytes
    push_frame(2, 1'b0);
    req = 4'b0100;
    cyc();
    req = '0;
    cyc();
    cyc();
    chk("mf_bytes_left", 32'(exp_q.size()), 32'(NB - 2));
    rst_n = 1'b0;
    #1;
    chk("mf_valid", 32'(tx_data_valid), 32'd0);
    chk("mf_gnt", 32'(gnt), 32'd0);
    chk("mf_busy", 32'(busy), 32'd0);
    chk("mf_done", 32'(done), 32'd0);
    exp_q.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 6; n++) begin
      cyc();
      if (|done || busy) got = 1'b1;
    end
    chk("mf_no_done", 32'(got), 32'd0);
    push_frame(1, 1'b0);
    push_frame(3, 1'b0);
    req = 4'b1010;
    run_done(1'b0, 40, who);
    chk("mf_first", 32'(who), 32'b0010);
    run_done(1'b0, 40, who);
    chk("mf_second", 32'(who), 32'b1000);
    cyc();

    // Round robin from a fresh rr_ptr
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) push_frame(i, 1'b0);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      run_done(1'b0, 40, who);
      chk("rr_order", 32'(who), 32'(4'b0001 << i));
    end
    cyc();
    push_frame(0, 1'b0);
    push_frame(3, 1'b0);
    req = 4'b1001;
    run_done(1'b0, 40, who);
    chk("rr_1001_a", 32'(who), 32'b0001);
    run_done(1'b0, 40, who);
    chk("rr_1001_b", 32'(who), 32'b1000);
    chk("rr_sb_empty", 32'(exp_q.size()), 32'd0);

    // Inter-frame gap, 50 MHz / 115200 baud, one bit-time
    rdy_b = 1'b1;
    push_frame(3, 1'b1);
    req_b = 4'b0001;
    cnt  = 0;
    last = 0;
    gap  = -1;
    got  = 1'b0;
    for (int n = 0; n < 700 && !got; n++) begin
      cyc();
      cnt++;
      req_b = '0;
      if (valid_b && rdy_b) begin
        chk("gap_byte", 32'(tx_data_b), (exp_b.size() > 0) ? 32'(exp_b.pop_front()) : 32'hxx);
        last = cnt;
      end
      if (|done_b) begin
        got = 1'b1;
        gap = cnt - (last + 1);
        chk("gap_done_who", 32'(done_b), 32'b0001);
        chk("gap_gnt", 32'(gnt_b), 32'b0001);
      end
    end
    chk("gap_done_seen", 32'(got), 32'd1);
    chk("gap_cycles", 32'(gap), 32'd434);
    chk("gap_sb_empty", 32'(exp_b.size()), 32'd0);
    cyc();
    chk("gap_busy_fall", 32'(busy_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter byte port between NREQ requesters, each of which presents a complete BN-byte frame. The arbiter grants requesters round-robin, latches the granted frame, and serializes it MSB-byte-first into the transmitter's valid/ready byte interface. After each frame it holds a programmable inter-frame gap, then reports completion to the requester. It sits between the protocol-layer frame producers and the single `uart_tx` instance, mirroring the BN-byte framing used on the receive side.

## Interface
- `NREQ`, 4: number of requesters; range 2..8.
- `BN`, 4: bytes per frame; range 1..15.
- `CLK_FRE`, 50: clock frequency in MHz.
- `BAUD_RATE`, 115200: line rate, used only for gap timing.
- `GAP_BITS`, 1: inter-frame idle in bit-times. Gap cycles = GAP_BITS*CLK_FRE*1000000/BAUD_RATE, truncated. 0 means no gap.
- `sys_clk` in 1: the single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in NREQ: per-requester level request.
- `req_data` in NREQ*BN*8: frame of requester i at bits [(i+1)*BN*8-1 -: BN*8].
- `gnt` out NREQ: one-hot, high from latch until end of gap; reset 0.
- `done` out NREQ: one-cycle pulse to the granted requester at end of gap; reset 0.
- `busy` out 1: high in any state other than IDLE; reset 0.
- `tx_data` out 8: byte to transmitter; reset 0.
- `tx_data_valid` out 1: byte offered; reset 0.
- `tx_data_ready` in 1: transmitter accepts the byte.

## Operation
- States: IDLE, SEND, GAP, DONE.
- **IDLE**
  - If `req` is nonzero, select the winner: the first set bit searching upward from `rr_ptr` with wrap-around.
  - At the clock edge: latch that requester's `req_data` into the frame register, set `gnt`, clear the byte counter, drive `tx_data` with the top byte, assert `tx_data_valid`, and go to SEND.
- **SEND**
  - A byte transfers on an edge where `tx_data_valid` and `tx_data_ready` are both 1.
  - On transfer: increment the counter, load the next byte, and keep `tx_data_valid` high.
  - After the last byte transfers: drop `tx_data_valid`, load the gap counter, and go to GAP.
  - `tx_data` and `tx_data_valid` must not change while `tx_data_valid`=1 and `tx_data_ready`=0.
- **GAP**
  - Count down the gap cycles, then go to DONE.
  - With 0 gap cycles, go directly from SEND to DONE.
- **DONE**
  - Pulse `done[winner]` for one cycle, set `rr_ptr` = winner+1 mod NREQ, clear `gnt`, and return to IDLE.
- Byte order: byte BN-1 (bits BN*8-1:BN*8-8) is sent first, byte 0 last.
- `req_data` only needs to be stable in the arbitration cycle. Later changes do not affect the frame in flight.
- A requester must drop `req` in the cycle after `done`. If it is still high, it is treated as a new request and rotates behind other pending requesters.
- Requests arriving outside IDLE wait; none are lost while held high.
- Deasserting `req` after grant does not abort the frame.
- Reset at any time: all outputs 0 immediately, frame abandoned, no `done` pulse, `rr_ptr`=0, state IDLE.
- Counter widths: byte counter is 4 bits; gap counter is sized with $clog2 of gap cycles + 1.

## Timing
- Request-to-first-valid latency: 1 cycle. With `req` seen high at edge k in IDLE, `tx_data_valid`=1 after edge k.
- With `tx_data_ready` tied to 1: the frame occupies BN cycles in SEND, then gap cycles in GAP, then 1 cycle in DONE.
- Back-to-back frames: the minimum spacing between two frames' first bytes is BN+gap+2 cycles.

## Configuration
- Macro: `UART_TX_ARB_CHKSUM_EN`.
- **Defined:** after byte 0, SEND transmits one extra byte, the XOR of all BN frame bytes, computed at latch time. The frame becomes BN+1 bytes on the line.
- **Undefined:** exactly BN bytes are sent, and no checksum logic is synthesized.

## Test plan
- **Single frame.** NREQ=4, BN=4, GAP_BITS=0, `tx_data_ready`=1; `req`[2]=1 with data 0xA1B2C3D4 -> bytes A1,B2,C3,D4 on consecutive cycles, `gnt`=0100, then `done`[2] pulses; `busy` falls on the next cycle.
- **Backpressure.** `tx_data_ready` toggles 1,0,0,1,... -> each byte is held stable while ready is 0, and no byte is duplicated or skipped.
- **Round robin.** `req`=1111 held continuously, each requester dropping `req` after its `done` -> grant order 0,1,2,3. Then `req`=1001 again -> grant 0 then 3.
- **Gap.** CLK_FRE=50, BAUD_RATE=115200, GAP_BITS=1 -> exactly 434 cycles between the last accepted byte and the `done` pulse.
- **Checksum.** With `UART_TX_ARB_CHKSUM_EN` defined, frame 0x01020304 -> bytes 01,02,03,04,04.
- **Reset mid-frame.** `rst_n` asserted after 2 bytes -> `tx_data_valid`, `gnt`, `busy` go to 0 asynchronously and no `done` occurs. After release, a new `req`[1] is served first with `rr_ptr`=0 semantics.
